mmio_uart: RTL and testbench
============================

MMIO_UART -- requirements
Module: mmio_uart

Interface
REQ-001 Parameter TX_DEPTH, default 8: TX FIFO depth in bytes (power of two).
REQ-002 Parameter BAUD_DIV, default 433: reset value of the divisor register; one bit lasts DIV+1 clk cycles.
REQ-003 Clock and reset: one clock; reset is asynchronous and active-high.
REQ-004 clk  input  1  rising-edge system clock.
REQ-005 reset  input  1  asynchronous active-high reset.
REQ-006 addr  input  8  byte offset; addr[1:0] ignored.
REQ-007 data_in  input  32  CPU store data.
REQ-008 data_out  output  32  CPU load data.
REQ-009 enable  input  1  access strobe, valid for one cycle per access.
REQ-010 read_write  input  1  1 = read, 0 = write.
REQ-011 tx  output  1  serial transmit line, idle high.
REQ-012 rx  input  1  serial receive line, asynchronous to clk.

Function
REQ-013 Register map: 0x00 TXDATA (W), 0x04 RXDATA (R), 0x08 STATUS (R), 0x0C DIV (R/W, bits [15:0]); unmapped offsets read 0 and ignore writes.
REQ-014 data_out is combinational from addr when enable & read_write, else 0; read side effects commit on the rising edge ending the access.
REQ-015 Writes commit on the rising edge where enable=1 and read_write=0.
REQ-016 TXDATA write pushes data_in[7:0]; when full and no pop that cycle, the byte is dropped and sticky tx_overflow is set; simultaneous push and pop on a full FIFO is accepted.
REQ-017 STATUS bits: 0 tx_full, 1 tx_empty, 2 tx_busy (serializer not IDLE), 3 rx_valid, 4 tx_overflow, 5 rx_overrun, 6 rx_frame_err; others 0; a STATUS read clears bits 4-6.
REQ-018 TX FSM states IDLE, START, DATA, STOP; IDLE with FIFO non-empty pops the head, latches DIV and moves to START on the next edge.
REQ-019 tx = 0 in START, byte bits LSB first in DATA (8 bits), 1 in STOP and IDLE; each state/bit holds exactly DIV+1 cycles.
REQ-020 STOP with FIFO non-empty goes directly to START (back-to-back frames, no idle gap); otherwise IDLE.
REQ-021 A DIV write during a frame does not affect that frame; it applies from the next START.
REQ-022 Latency: TXDATA written at edge N into an empty FIFO with TX idle -> tx low after edge N+1.
REQ-023 FIFO pointers wrap modulo TX_DEPTH; count is log2(TX_DEPTH)+1 bits.

Reset
REQ-024 On reset: tx=1, FIFO empty, FSM IDLE, DIV=BAUD_DIV, all sticky bits 0, rx_valid=0, RX FSM idle; data_out follows REQ-014.
REQ-025 Reset mid-frame aborts the frame immediately, driving tx=1 without completing the stop bit.

Configuration
REQ-026 Macro MMIO_UART_RX_EN compiles in the receiver; without it RXDATA reads 0, STATUS bits 3, 5 and 6 read 0, and rx is unused.
REQ-027 With MMIO_UART_RX_EN: rx passes a 2-flop synchronizer; a falling edge starts a frame; each bit is sampled at cycle (DIV+1)/2 of its period; 8 data bits LSB first; then the stop bit.
REQ-028 Stop bit 0: byte discarded, rx_frame_err set; good byte while rx_valid=1: byte discarded, rx_overrun set; else byte stored and rx_valid set.
REQ-029 An RXDATA read returns {24'b0, byte} and clears rx_valid at that edge; a byte completing on the same edge is stored and rx_valid stays 1.

Structure
REQ-030 Register offsets, STATUS bit indices and TX FSM state encodings live in a shared header used by software tests and this block.
REQ-031 The TX FIFO is a sub-module sync_fifo (WIDTH, DEPTH parameters, push/pop/full/empty/count).

Verification
REQ-032 DIV=3, write 0x55 to TXDATA -> tx low 4 cycles, then 1,0,1,0,1,0,1,0 each 4 cycles, then high 4 cycles; STATUS tx_busy=1 throughout, 0 after.
REQ-033 Write 9 bytes in 9 consecutive cycles with DIV=433 -> first 8 accepted (after the first pop), 9th accepted, a 10th dropped; STATUS bit4=1, then 0 on the second STATUS read.
REQ-034 Two bytes 0xA5, 0x3C queued -> the second start bit directly follows the first stop bit, no idle cycle.
REQ-035 With MMIO_UART_RX_EN, drive frame 0xC3 at DIV=7 -> STATUS=0x0A (rx_valid, tx_empty); RXDATA reads 0x000000C3; next STATUS bit3=0.
REQ-036 Drive two RX frames without reading -> RXDATA holds first byte, STATUS bit5=1; frame with stop bit 0 -> bit6=1, rx_valid unchanged.
REQ-037 Assert reset mid-DATA -> tx=1 in the same cycle, STATUS reads 0x02 after release, DIV reads 433.

Source files
------------

// File: rtl/mmio_uart_pkg.sv
// rtl/mmio_uart_pkg.sv - shared register offsets, STATUS bit indices and FSM encodings
package mmio_uart_pkg;

  localparam logic [7:0] OFF_TXDATA = 8'h00;
  localparam logic [7:0] OFF_RXDATA = 8'h04;
  localparam logic [7:0] OFF_STATUS = 8'h08;
  localparam logic [7:0] OFF_DIV    = 8'h0C;

  localparam int ST_TX_FULL      = 0;
  localparam int ST_TX_EMPTY     = 1;
  localparam int ST_TX_BUSY      = 2;
  localparam int ST_RX_VALID     = 3;
  localparam int ST_TX_OVERFLOW  = 4;
  localparam int ST_RX_OVERRUN   = 5;
  localparam int ST_RX_FRAME_ERR = 6;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_t;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_t;

  // Word index of a byte offset; the two low address bits never select a register.
  function automatic logic [5:0] reg_index(input logic [7:0] off);
    return off[7:2];
  endfunction

endpackage

// File: rtl/mmio_uart_if.sv
// rtl/mmio_uart_if.sv - CPU register bus between a bus master and the UART
interface mmio_uart_if;
  logic [7:0]  addr;
  logic [31:0] data_in;
  logic [31:0] data_out;
  logic        enable;
  logic        read_write;

  modport master (output addr, data_in, enable, read_write, input data_out);
  modport slave  (input addr, data_in, enable, read_write, output data_out);
endinterface

// File: rtl/mmio_uart_sync_fifo.sv
// rtl/mmio_uart_sync_fifo.sv - synchronous FIFO with show-ahead head and occupancy count
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  // A push into a full FIFO is still taken when the head leaves on the same edge.
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign full     = (count == (AW+1)'(DEPTH));
  assign empty    = (count == '0);
  assign pop_data = mem[rd_ptr];

  // Data array write; contents need no reset because count guards every read.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Pointers wrap naturally at the power-of-two depth; count tracks occupancy.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/mmio_uart.sv
// rtl/mmio_uart.sv - memory-mapped UART, TX FIFO + serializer; receiver under MMIO_UART_RX_EN
module mmio_uart
  import mmio_uart_pkg::*;
#(
  parameter int TX_DEPTH = 8,
  parameter int BAUD_DIV = 433
) (
  input  logic        clk,
  input  logic        reset,
  mmio_uart_if.slave  bus,
  output logic        tx,
  input  logic        rx
);
  localparam int CW = $clog2(TX_DEPTH) + 1;

  logic [5:0]  idx;
  logic        rd_en, wr_en;
  logic        wr_txdata, wr_div, rd_status, rd_rxdata;
  logic [15:0] div;
  logic [17:0] unused_bus;
  logic [31:0] status;

  assign idx        = bus.addr[7:2];
  assign rd_en      = bus.enable & bus.read_write;
  assign wr_en      = bus.enable & ~bus.read_write;
  assign wr_txdata  = wr_en && (idx == reg_index(OFF_TXDATA));
  assign wr_div     = wr_en && (idx == reg_index(OFF_DIV));
  assign rd_status  = rd_en && (idx == reg_index(OFF_STATUS));
  assign rd_rxdata  = rd_en && (idx == reg_index(OFF_RXDATA));
  assign unused_bus = {bus.data_in[31:16], bus.addr[1:0]};

  // Divisor register; the serializers copy it at frame start.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)       div <= 16'(BAUD_DIV);
    else if (wr_div) div <= bus.data_in[15:0];
  end

  logic          fifo_pop, fifo_full, fifo_empty;
  logic [7:0]    fifo_head;
  logic [CW-1:0] unused_count;

  sync_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (wr_txdata),
    .push_data (bus.data_in[7:0]),
    .pop       (fifo_pop),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (unused_count)
  );

  tx_state_t   tx_state, tx_state_nx;
  logic [15:0] tx_cnt, tx_cnt_nx, tx_div, tx_div_nx;
  logic [2:0]  tx_bit, tx_bit_nx;
  logic [7:0]  tx_shift, tx_shift_nx;
  logic        tx_bit_end, tx_load;

  // TX serializer registers; reset aborts any frame in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_state <= TX_IDLE;
      tx_cnt   <= '0;
      tx_div   <= '0;
      tx_bit   <= '0;
      tx_shift <= '0;
    end else begin
      tx_state <= tx_state_nx;
      tx_cnt   <= tx_cnt_nx;
      tx_div   <= tx_div_nx;
      tx_bit   <= tx_bit_nx;
      tx_shift <= tx_shift_nx;
    end
  end

  // TX next state and line level; every state/bit lasts tx_div+1 cycles.
  always_comb begin
    tx_state_nx = tx_state;
    tx_cnt_nx   = tx_cnt;
    tx_div_nx   = tx_div;
    tx_bit_nx   = tx_bit;
    tx_shift_nx = tx_shift;
    fifo_pop    = 1'b0;
    tx_load     = 1'b0;
    tx          = 1'b1;
    tx_bit_end  = (tx_cnt == tx_div);
    if (tx_state != TX_IDLE) tx_cnt_nx = tx_bit_end ? 16'd0 : tx_cnt + 16'd1;
    case (tx_state)
      TX_IDLE:  tx_load = !fifo_empty;
      TX_START: begin
        tx = 1'b0;
        if (tx_bit_end) begin
          tx_state_nx = TX_DATA;
          tx_bit_nx   = 3'd0;
        end
      end
      TX_DATA: begin
        tx = tx_shift[0];
        if (tx_bit_end) begin
          if (tx_bit == 3'd7) begin
            tx_state_nx = TX_STOP;
          end else begin
            tx_shift_nx = {1'b0, tx_shift[7:1]};
            tx_bit_nx   = tx_bit + 3'd1;
          end
        end
      end
      TX_STOP: begin
        if (tx_bit_end) begin
          if (!fifo_empty) tx_load = 1'b1;
          else             tx_state_nx = TX_IDLE;
        end
      end
      default: tx_state_nx = TX_IDLE;
    endcase
    if (tx_load) begin
      fifo_pop    = 1'b1;
      tx_shift_nx = fifo_head;
      tx_div_nx   = div;
      tx_cnt_nx   = 16'd0;
      tx_state_nx = TX_START;
    end
  end

  logic tx_overflow;

  // Sticky overflow; a new drop wins over a same-edge STATUS read.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                      tx_overflow <= 1'b0;
    else if (wr_txdata && fifo_full && !fifo_pop)   tx_overflow <= 1'b1;
    else if (rd_status)                             tx_overflow <= 1'b0;
  end

  logic       rx_valid, rx_overrun, rx_frame_err;
  logic [7:0] rx_data;

`ifdef MMIO_UART_RX_EN
  logic        rx_s1, rx_s2, rx_prev;
  rx_state_t   rx_state, rx_state_nx;
  logic [15:0] rx_cnt, rx_cnt_nx, rx_div, rx_div_nx, rx_half;
  logic [2:0]  rx_bit, rx_bit_nx;
  logic [7:0]  rx_shift, rx_shift_nx;
  logic        rx_done, rx_stop_ok, rx_good, rx_keep;

  assign rx_half = 16'(({1'b0, rx_div} + 17'd1) >> 1);
  assign rx_good = rx_done && rx_stop_ok;
  assign rx_keep = rx_valid && !rd_rxdata;

  // Two-flop synchronizer plus one more stage for falling-edge detection.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_s1   <= 1'b1;
      rx_s2   <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_s1   <= rx;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
    end
  end

  // RX deserializer registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      rx_div   <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
    end else begin
      rx_state <= rx_state_nx;
      rx_cnt   <= rx_cnt_nx;
      rx_div   <= rx_div_nx;
      rx_bit   <= rx_bit_nx;
      rx_shift <= rx_shift_nx;
    end
  end

  // RX next state; bits sampled mid-period, frame ends at the stop-bit sample.
  always_comb begin
    rx_state_nx = rx_state;
    rx_cnt_nx   = rx_cnt;
    rx_div_nx   = rx_div;
    rx_bit_nx   = rx_bit;
    rx_shift_nx = rx_shift;
    rx_done     = 1'b0;
    rx_stop_ok  = 1'b0;
    if (rx_state == RX_IDLE) begin
      if (rx_prev && !rx_s2) begin
        rx_state_nx = RX_START;
        rx_cnt_nx   = 16'd0;
        rx_div_nx   = div;
      end
    end else begin
      rx_cnt_nx = (rx_cnt == rx_div) ? 16'd0 : rx_cnt + 16'd1;
      if (rx_state == RX_DATA && rx_cnt == rx_half) rx_shift_nx = {rx_s2, rx_shift[7:1]};
      if (rx_state == RX_STOP && rx_cnt == rx_half) begin
        rx_done     = 1'b1;
        rx_stop_ok  = rx_s2;
        rx_state_nx = RX_IDLE;
      end else if (rx_cnt == rx_div) begin
        if (rx_state == RX_START) begin
          rx_state_nx = RX_DATA;
          rx_bit_nx   = 3'd0;
        end else if (rx_state == RX_DATA) begin
          rx_bit_nx = rx_bit + 3'd1;
          if (rx_bit == 3'd7) rx_state_nx = RX_STOP;
        end
      end
    end
  end

  // Received byte holding register and sticky error flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_data      <= '0;
      rx_valid     <= 1'b0;
      rx_overrun   <= 1'b0;
      rx_frame_err <= 1'b0;
    end else begin
      if (rx_done && !rx_stop_ok) rx_frame_err <= 1'b1;
      else if (rd_status)         rx_frame_err <= 1'b0;
      if (rx_good && rx_keep)     rx_overrun <= 1'b1;
      else if (rd_status)         rx_overrun <= 1'b0;
      if (rx_good && !rx_keep) begin
        rx_data  <= rx_shift;
        rx_valid <= 1'b1;
      end else if (rd_rxdata) begin
        rx_valid <= 1'b0;
      end
    end
  end
`else
  logic unused_rx;
  logic unused_rd_rxdata;
  assign unused_rx        = rx;
  assign unused_rd_rxdata = rd_rxdata;
  assign rx_data          = '0;
  assign rx_valid         = 1'b0;
  assign rx_overrun       = 1'b0;
  assign rx_frame_err     = 1'b0;
`endif

  // STATUS word assembly.
  always_comb begin
    status                  = '0;
    status[ST_TX_FULL]      = fifo_full;
    status[ST_TX_EMPTY]     = fifo_empty;
    status[ST_TX_BUSY]      = (tx_state != TX_IDLE);
    status[ST_RX_VALID]     = rx_valid;
    status[ST_TX_OVERFLOW]  = tx_overflow;
    status[ST_RX_OVERRUN]   = rx_overrun;
    status[ST_RX_FRAME_ERR] = rx_frame_err;
  end

  // Combinational read mux; zero outside a read access.
  always_comb begin
    bus.data_out = '0;
    if (rd_en) begin
      if (idx == reg_index(OFF_RXDATA))      bus.data_out = {24'd0, rx_data};
      else if (idx == reg_index(OFF_STATUS)) bus.data_out = status;
      else if (idx == reg_index(OFF_DIV))    bus.data_out = {16'd0, div};
    end
  end
endmodule

// File: tb/tb_mmio_uart.sv
// tb/tb_mmio_uart.sv - table-driven register checks plus directed TX/RX line sequences
module tb_mmio_uart;
  import mmio_uart_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic rx = 1'b1;
  logic tx;

  mmio_uart_if bus_if ();

  mmio_uart #(.TX_DEPTH(8), .BAUD_DIV(433)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if),
    .tx    (tx),
    .rx    (rx)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[15];
  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [7:0] a, input logic [31:0] d);
    bus_if.addr = a; bus_if.data_in = d; bus_if.read_write = 1'b0; bus_if.enable = 1'b1;
    @(posedge clk);
    #1;
    bus_if.enable = 1'b0;
  endtask

  task automatic bus_read(input logic [7:0] a, output logic [31:0] d, output logic t);
    bus_if.addr = a; bus_if.read_write = 1'b1; bus_if.enable = 1'b1;
    #2;
    d = bus_if.data_out;
    t = tx;
    @(posedge clk);
    #1;
    bus_if.enable = 1'b0;
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop_bit);
    logic [9:0] frame;
    frame = {stop_bit, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx = frame[i];
      repeat (8) tick();
    end
    rx = 1'b1;
    repeat (4) tick();
  endtask

  logic [31:0] rd;
  logic        t;
  logic [9:0]  frame10;
  logic [19:0] frame20;

  initial begin
    bus_if.addr = '0; bus_if.data_in = '0; bus_if.enable = 1'b0; bus_if.read_write = 1'b0;
    vecs[0]  = '{1'b0, 8'h08, 32'h0,          32'h0000_0002};
    vecs[1]  = '{1'b0, 8'h0C, 32'h0,          32'd433};
    vecs[2]  = '{1'b0, 8'h00, 32'h0,          32'h0};
    vecs[3]  = '{1'b0, 8'h04, 32'h0,          32'h0};
    vecs[4]  = '{1'b0, 8'h10, 32'h0,          32'h0};
    vecs[5]  = '{1'b0, 8'hFC, 32'h0,          32'h0};
    vecs[6]  = '{1'b1, 8'h0C, 32'hABCD_1234,  32'h0};
    vecs[7]  = '{1'b0, 8'h0C, 32'h0,          32'h0000_1234};
    vecs[8]  = '{1'b0, 8'h0F, 32'h0,          32'h0000_1234};
    vecs[9]  = '{1'b1, 8'h10, 32'hFFFF_FFFF,  32'h0};
    vecs[10] = '{1'b0, 8'h10, 32'h0,          32'h0};
    vecs[11] = '{1'b0, 8'h0C, 32'h0,          32'h0000_1234};
    vecs[12] = '{1'b1, 8'h0C, 32'h0000_0003,  32'h0};
    vecs[13] = '{1'b0, 8'h0C, 32'h0,          32'h0000_0003};
    vecs[14] = '{1'b0, 8'h08, 32'h0,          32'h0000_0002};

    repeat (2) tick();
    check("reset_tx", {31'd0, tx}, 32'd1);
    reset = 1'b0;
    tick();
    check("reset_tx_after_release", {31'd0, tx}, 32'd1);
    #2 check("idle_data_out", bus_if.data_out, 32'h0);
    tick();

    for (int i = 0; i < 15; i++) begin
      if (vecs[i].wr) bus_write(vecs[i].addr, vecs[i].wdata);
      else begin
        bus_read(vecs[i].addr, rd, t);
        check($sformatf("vec%0d_addr%02h", i, vecs[i].addr), rd, vecs[i].exp);
      end
    end

    // Single frame 0x55 at DIV=3
    frame10 = {1'b1, 8'h55, 1'b0};
    bus_write(OFF_TXDATA, 32'h0000_0055);
    check("latency_still_idle", {31'd0, tx}, 32'd1);
    tick();
    for (int c = 0; c < 40; c++) begin
      bus_read(OFF_STATUS, rd, t);
      check($sformatf("frame55_tx_c%0d", c), {31'd0, t}, {31'd0, frame10[c/4]});
      check($sformatf("frame55_busy_c%0d", c), {31'd0, rd[ST_TX_BUSY]}, 32'd1);
    end
    bus_read(OFF_STATUS, rd, t);
    check("frame55_done_status", rd, 32'h0000_0002);
    check("frame55_done_tx", {31'd0, t}, 32'd1);

    // Back-to-back frames 0xA5 then 0x3C with no idle gap
    frame20 = {1'b1, 8'h3C, 1'b0, 1'b1, 8'hA5, 1'b0};
    bus_write(OFF_TXDATA, 32'h0000_00A5);
    bus_write(OFF_TXDATA, 32'h0000_003C);
    for (int c = 0; c < 80; c++) begin
      bus_read(OFF_STATUS, rd, t);
      check($sformatf("b2b_tx_c%0d", c), {31'd0, t}, {31'd0, frame20[c/4]});
    end
    bus_read(OFF_STATUS, rd, t);
    check("b2b_done_status", rd, 32'h0000_0002);

    // FIFO fill and overflow at DIV=433
    bus_write(OFF_DIV, 32'd433);
    for (int i = 0; i < 9; i++) bus_write(OFF_TXDATA, 32'(i + 1));
    bus_read(OFF_STATUS, rd, t);
    check("fill9_status", rd, 32'h0000_0005);
    bus_write(OFF_TXDATA, 32'h0000_00EE);
    bus_read(OFF_STATUS, rd, t);
    check("overflow_status", rd, 32'h0000_0015);
    bus_read(OFF_STATUS, rd, t);
    check("overflow_cleared", rd, 32'h0000_0005);

    // Reset mid-DATA
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    bus_write(OFF_DIV, 32'd3);
    bus_write(OFF_TXDATA, 32'h0000_0000);
    repeat (7) tick();
    check("mid_data_low", {31'd0, tx}, 32'd0);
    reset = 1'b1;
    #1 check("reset_mid_frame_tx", {31'd0, tx}, 32'd1);
    tick();
    reset = 1'b0;
    tick();
    bus_read(OFF_STATUS, rd, t);
    check("post_reset_status", rd, 32'h0000_0002);
    bus_read(OFF_DIV, rd, t);
    check("post_reset_div", rd, 32'd433);
    repeat (5) tick();
    check("post_reset_tx_idle", {31'd0, tx}, 32'd1);

`ifdef MMIO_UART_RX_EN
    bus_write(OFF_DIV, 32'd7);
    send_rx(8'hC3, 1'b1);
    bus_read(OFF_STATUS, rd, t);
    check("rx_c3_status", rd, 32'h0000_000A);
    bus_read(OFF_RXDATA, rd, t);
    check("rx_c3_data", rd, 32'h0000_00C3);
    bus_read(OFF_STATUS, rd, t);
    check("rx_c3_status_after", rd, 32'h0000_0002);
    send_rx(8'h11, 1'b1);
    send_rx(8'h22, 1'b1);
    bus_read(OFF_STATUS, rd, t);
    check("rx_overrun_status", rd, 32'h0000_002A);
    send_rx(8'h33, 1'b0);
    bus_read(OFF_STATUS, rd, t);
    check("rx_frame_err_status", rd, 32'h0000_004A);
    bus_read(OFF_RXDATA, rd, t);
    check("rx_first_byte_kept", rd, 32'h0000_0011);
    bus_read(OFF_STATUS, rd, t);
    check("rx_final_status", rd, 32'h0000_0002);
`else
    rx = 1'b0;
    repeat (20) tick();
    rx = 1'b1;
    repeat (20) tick();
    bus_read(OFF_STATUS, rd, t);
    check("no_rx_status", rd, 32'h0000_0002);
    bus_read(OFF_RXDATA, rd, t);
    check("no_rx_data", rd, 32'h0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
